// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - reorder-buffer controller driving register file rename and commit ports
// In-order retire with one-cycle flush on a mispredicted branch at head.
module rob_commit_ctrl #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 5,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              disp_valid,
    input  logic [REG_W-1:0]  disp_rd,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [REG_W-1:0]  reg_to_rename,
    output logic [TAG_W-1:0]  tag_rename,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_mispred,
    input  logic [DATA_W-1:0] wb_target,
    output logic              if_commit,
    output logic [REG_W-1:0]  pos_commit,
    output logic [DATA_W-1:0] data_commit,
    output logic [TAG_W-1:0]  tag_commit,
    output logic              clear,
    output logic [DATA_W-1:0] pc_redirect
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [TAG_W-1:0] MAX_TAG = TAG_W'(DEPTH);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_ready;
    logic [DEPTH-1:0]  ent_mispred;
    logic [REG_W-1:0]  ent_rd     [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];
    logic [DATA_W-1:0] ent_target [DEPTH];

    logic             accept;
    logic             wb_hit;
    logic             commit;
    logic             flush;
    logic [PTR_W-1:0] wb_idx;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        disp_ready    = (count < FULL) && !clear;
        accept        = disp_valid && disp_ready && rdy;
        disp_tag      = TAG_W'(tail) + TAG_W'(1);
        reg_to_rename = accept ? disp_rd : '0;
        tag_rename    = accept ? disp_tag : '0;
        wb_idx        = PTR_W'(wb_tag - TAG_W'(1));
        // Tag 0 and tags beyond DEPTH alias real slots after truncation, so range-check first.
        wb_hit        = wb_valid && rdy && !clear && (wb_tag != '0) && (wb_tag <= MAX_TAG)
                        && ent_valid[wb_idx];
        commit        = rdy && !clear && ent_valid[head] && ent_ready[head];
        flush         = commit && ent_mispred[head];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ent_valid   <= '0;
            ent_ready   <= '0;
            if_commit   <= 1'b0;
            pos_commit  <= '0;
            data_commit <= '0;
            tag_commit  <= '0;
            clear       <= 1'b0;
            pc_redirect <= '0;
        end else if (rdy) begin
            if_commit <= commit;
            clear     <= flush;
            if (commit) begin
                pos_commit  <= ent_rd[head];
                data_commit <= ent_data[head];
                tag_commit  <= TAG_W'(head) + TAG_W'(1);
            end
            if (flush) begin
                pc_redirect <= ent_target[head];
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                ent_valid   <= '0;
                ent_ready   <= '0;
            end else begin
                if (accept) begin
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= 1'b0;
                    tail            <= nxt(tail);
                end
                if (wb_hit) begin
                    ent_ready[wb_idx] <= 1'b1;
                end
                if (commit) begin
                    ent_valid[head] <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= nxt(head);
                end
                case ({accept, commit})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end else begin
            if_commit <= 1'b0;
            clear     <= 1'b0;
        end
    end

    // Payload fields need no reset: they are only observed behind valid/ready.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_rd[tail] <= disp_rd;
        end
        if (wb_hit) begin
            ent_data[wb_idx]    <= wb_data;
            ent_mispred[wb_idx] <= wb_mispred;
            ent_target[wb_idx]  <= wb_target;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - directed scoreboard bench for rob_commit_ctrl
module tb_rob_commit_ctrl;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              disp_valid;
    logic [REG_W-1:0]  disp_rd;
    logic              disp_ready;
    logic [TAG_W-1:0]  disp_tag;
    logic [REG_W-1:0]  reg_to_rename;
    logic [TAG_W-1:0]  tag_rename;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              wb_mispred;
    logic [DATA_W-1:0] wb_target;
    logic              if_commit;
    logic [REG_W-1:0]  pos_commit;
    logic [DATA_W-1:0] data_commit;
    logic [TAG_W-1:0]  tag_commit;
    logic              clear;
    logic [DATA_W-1:0] pc_redirect;

    rob_commit_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .reg_to_rename(reg_to_rename), .tag_rename(tag_rename),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_mispred(wb_mispred), .wb_target(wb_target),
        .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
        .tag_commit(tag_commit), .clear(clear), .pc_redirect(pc_redirect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REG_W-1:0] rd;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t              sb [$];
    logic [DATA_W-1:0] mdata [0:31];
    int                m_tail;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (if_commit === 1'b1) begin
            check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pos_commit", 64'(pos_commit), 64'(e.rd));
                check("tag_commit", 64'(tag_commit), 64'(e.tag));
                check("data_commit", 64'(data_commit), 64'(mdata[e.tag]));
            end
        end
    endtask

    task automatic dispatch(input logic [REG_W-1:0] rd);
        exp_t e;
        disp_valid = 1'b1;
        disp_rd    = rd;
        #1;
        e.rd  = rd;
        e.tag = TAG_W'(m_tail + 1);
        check("disp_ready", 64'(disp_ready), 64'd1);
        check("tag_rename", 64'(tag_rename), 64'(e.tag));
        check("reg_to_rename", 64'(reg_to_rename), 64'(rd));
        sb.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic wb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                      input logic mis, input logic [DATA_W-1:0] tgt, input bit take);
        wb_valid   = 1'b1;
        wb_tag     = tag;
        wb_data    = data;
        wb_mispred = mis;
        wb_target  = tgt;
        if (take) mdata[tag] = data;
        tick();
        wb_valid   = 1'b0;
        wb_mispred = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_tail = 0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; disp_valid = 1'b0; disp_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0; wb_mispred = 1'b0; wb_target = '0;
        m_tail = 0;
        for (int i = 0; i < 32; i++) mdata[i] = '0;

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_commit", 64'(if_commit), 64'd0);
        check("rst_clear", 64'(clear), 64'd0);
        check("rst_pos_commit", 64'(pos_commit), 64'd0);
        check("rst_data_commit", 64'(data_commit), 64'd0);
        check("rst_tag_commit", 64'(tag_commit), 64'd0);
        check("rst_pc_redirect", 64'(pc_redirect), 64'd0);
        check("rst_disp_tag", 64'(disp_tag), 64'd1);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        rst = 1'b0;

        // in-order retire with out-of-order writebacks
        dispatch(5'd3); dispatch(5'd4); dispatch(5'd5);
        wb(5'd3, 32'hC, 1'b0, '0, 1'b1);
        check("ooo_no_commit_a", 64'(if_commit), 64'd0);
        wb(5'd2, 32'hB, 1'b0, '0, 1'b1);
        check("ooo_no_commit_b", 64'(if_commit), 64'd0);
        wb(5'd1, 32'hA, 1'b0, '0, 1'b1);
        check("ooo_no_commit_c", 64'(if_commit), 64'd0);
        tick(); check("ooo_commit_1", 64'(if_commit), 64'd1);
        tick(); check("ooo_commit_2", 64'(if_commit), 64'd1);
        tick(); check("ooo_commit_3", 64'(if_commit), 64'd1);
        tick(); check("ooo_idle", 64'(if_commit), 64'd0);
        check("ooo_sb_empty", 64'(sb.size()), 64'd0);

        // asynchronous reset with 5 dispatches pending
        for (int i = 0; i < 5; i++) dispatch(REG_W'(6 + i));
        #2;
        rst = 1'b1;
        #1;
        check("mid_pos_commit", 64'(pos_commit), 64'd0);
        check("mid_data_commit", 64'(data_commit), 64'd0);
        check("mid_tag_commit", 64'(tag_commit), 64'd0);
        check("mid_if_commit", 64'(if_commit), 64'd0);
        check("mid_clear", 64'(clear), 64'd0);
        check("mid_disp_tag", 64'(disp_tag), 64'd1);
        check("mid_disp_ready", 64'(disp_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_tail = 0;

        // rdy gating with a ready head
        dispatch(5'd7);
        wb(5'd1, 32'h77, 1'b0, '0, 1'b1);
        rdy = 1'b0; disp_valid = 1'b1; disp_rd = 5'd8;
        #1;
        check("rdy_reg_to_rename", 64'(reg_to_rename), 64'd0);
        check("rdy_tag_rename", 64'(tag_rename), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_no_commit", 64'(if_commit), 64'd0);
            check("rdy_disp_tag", 64'(disp_tag), 64'd2);
        end
        disp_valid = 1'b0; rdy = 1'b1;
        tick(); check("rdy_commit", 64'(if_commit), 64'd1);
        tick(); check("rdy_idle", 64'(if_commit), 64'd0);

        // stale and out-of-range writebacks
        do_reset();
        dispatch(5'd9); dispatch(5'd10);
        wb(5'd0, 32'h55, 1'b0, '0, 1'b0);
        wb(5'd17, 32'h66, 1'b0, '0, 1'b0);
        tick(); check("stale_no_commit_a", 64'(if_commit), 64'd0);
        wb(5'd3, 32'h99, 1'b0, '0, 1'b0);
        tick(); check("stale_no_commit_b", 64'(if_commit), 64'd0);
        check("stale_disp_tag", 64'(disp_tag), 64'd3);
        wb(5'd1, 32'h91, 1'b0, '0, 1'b1);
        wb(5'd2, 32'h92, 1'b0, '0, 1'b1);
        check("stale_commit_1", 64'(if_commit), 64'd1);
        tick(); check("stale_commit_2", 64'(if_commit), 64'd1);
        check("stale_sb_empty", 64'(sb.size()), 64'd0);

        // full and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) dispatch(REG_W'(i + 1));
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        disp_valid = 1'b1; disp_rd = 5'd20;
        #1;
        check("full_reg_to_rename", 64'(reg_to_rename), 64'd0);
        check("full_tag_rename", 64'(tag_rename), 64'd0);
        check("full_disp_tag", 64'(disp_tag), 64'd1);
        tick();
        wb(5'd1, 32'h100, 1'b0, '0, 1'b1);
        check("full_no_bypass", 64'(reg_to_rename), 64'd0);
        tick();
        check("full_commit", 64'(if_commit), 64'd1);
        check("wrap_disp_ready", 64'(disp_ready), 64'd1);
        check("wrap_tag_rename", 64'(tag_rename), 64'd1);
        check("wrap_reg_to_rename", 64'(reg_to_rename), 64'd20);
        tick();
        disp_valid = 1'b0;
        check("wrap_disp_tag", 64'(disp_tag), 64'd2);

        // mispredict at head
        do_reset();
        for (int i = 1; i <= 4; i++) dispatch(REG_W'(i));
        wb(5'd2, 32'h22, 1'b1, 32'h1000, 1'b1);
        wb(5'd1, 32'h11, 1'b0, '0, 1'b1);
        tick();
        check("mp_commit_1", 64'(if_commit), 64'd1);
        check("mp_clear_early", 64'(clear), 64'd0);
        tick();
        check("mp_commit_2", 64'(if_commit), 64'd1);
        check("mp_clear", 64'(clear), 64'd1);
        check("mp_pc_redirect", 64'(pc_redirect), 64'h1000);
        check("mp_disp_ready", 64'(disp_ready), 64'd0);
        check("mp_disp_tag", 64'(disp_tag), 64'd1);
        disp_valid = 1'b1; disp_rd = 5'd6;
        #1;
        check("mp_reg_to_rename", 64'(reg_to_rename), 64'd0);
        disp_valid = 1'b0;
        sb.delete();
        m_tail = 0;
        tick();
        check("mp_clear_done", 64'(clear), 64'd0);
        check("mp_post_if_commit", 64'(if_commit), 64'd0);
        check("mp_post_disp_ready", 64'(disp_ready), 64'd1);
        check("mp_post_disp_tag", 64'(disp_tag), 64'd1);
        wb(5'd3, 32'h33, 1'b0, '0, 1'b0);
        tick(); check("mp_stale_a", 64'(if_commit), 64'd0);
        tick(); check("mp_stale_b", 64'(if_commit), 64'd0);
        check("mp_stale_disp_tag", 64'(disp_tag), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
